shift_mix_columns: RTL
======================

# shift_mix_columns

Round stage that sits directly downstream of the SubBytes stage in the AES datapath. It consumes the 128-bit substituted state and applies ShiftRows, then MixColumns, processing one 32-bit column per clock. It raises a one-cycle ready pulse with the registered result for the AddRoundKey stage. A last-round input bypasses MixColumns, as FIPS-197 requires.

## Interface
- No parameters. Constants are in the shared package.
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- En_SMC  in  1  start request; sampled only in IDLE
- Last_SMC  in  1  final round: skip MixColumns; sampled with En_SMC
- Inv_SMC  in  1  inverse mode; sampled with En_SMC; present only with SMC_INVERSE_EN
- In_SMC  in  128  input state, normally Out_SBT
- Out_SMC  out  128  result; held until the next completion
- Ry_SMC  out  1  one-cycle pulse: Out_SMC valid
- Busy_SMC  out  1  high in every state except IDLE

## Operation
- Byte k of the state is In_SMC[127-8k -: 8], with row r = k%4 and column c = k/4 (column-major, FIPS-197).
- ShiftRows: out[r][c] = in[r][(c+r)%4].
- MixColumns per column: b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3, over GF(2^8) mod 0x11B.
  - xtime: shift left by one; XOR 0x1B if bit 7 was set.
- FSM states: IDLE, COL, DONE.
  - IDLE, En_SMC=1: latch ShiftRows(In_SMC) into the state register and latch the mode bits.
    - Last_SMC=1: go to DONE.
    - Otherwise: clear col to 0 and go to COL.
  - COL: replace column col with MixColumns(column). col increments; after col=3, go to DONE.
  - DONE: load Out_SMC from the state register, pulse Ry_SMC, go to IDLE.
- En_SMC outside IDLE is ignored; nothing is queued.
- In_SMC is sampled only on the accepting edge and may change afterwards.
- col is a 2-bit counter; it wraps from 3 to 0 on the DONE transition.
- Reset at any time, including mid-operation:
  - FSM goes to IDLE, col=0, state register=0.
  - Out_SMC=0, Ry_SMC=0, Busy_SMC=0.
  - The partially processed state is discarded.

## Timing
- Edge E0 accepts En_SMC.
- Full round: columns 0..3 are written at E1..E4, DONE at E5.
  - Out_SMC updates and Ry_SMC is high for the cycle after E5.
  - Latency is 5 cycles; the next En_SMC can be accepted at E6.
- Last round: DONE at E1; Ry_SMC is high for the cycle after E1.
- Busy_SMC is high from after E0 until the DONE edge.
- Ry_SMC is never high for two consecutive cycles.
- Out_SMC changes only on DONE edges and on reset.

## Configuration
- SMC_INVERSE_EN defined:
  - The Inv_SMC port exists.
  - With Inv=1, IDLE latches In_SMC unshifted.
  - COL applies InvMixColumns with coefficients 0e, 0b, 0d, 09.
  - DONE loads InvShiftRows(state): out[r][c] = in[r][(c-r)%4].
  - The result is the exact inverse of the forward operation.
  - With Inv=1 and Last=1, only InvShiftRows is applied.
- SMC_INVERSE_EN undefined:
  - No Inv_SMC port.
  - Forward path only; no inverse multipliers are synthesized.

## Structure
- aes_pkg holds:
  - the state type, the FSM state encoding and the byte-index helper;
  - the xtime and gf_mul functions;
  - the MixColumns and InvMixColumns coefficient constants.
- One natural sub-module: mix_column_unit.
  - Combinational; 32-bit column in, 32-bit column out, plus an inverse select when SMC_INVERSE_EN is defined.
  - Instantiated once and fed by a column mux driven by col.

## Test plan
- Forward round: In=d42711aee0bf98f1b8b45de51e415230, Last=0, one-cycle En -> after 5 cycles Ry pulses once and Out=046681e5e0cb199a48f8d37a2806264c.
- Last round: same In with Last=1 -> Ry on the next cycle, Out=d4bf5d30e0b452aeb84111f11e2798e5.
- Inverse (SMC_INVERSE_EN): In=046681e5e0cb199a48f8d37a2806264c, Inv=1, Last=0 -> Out=d42711aee0bf98f1b8b45de51e415230.
- Busy ignore: En held high for 12 cycles with In changed after E0 -> exactly two results, both computed from the values sampled at the accepting edges; Ry pulses at cycles 5 and 11.
- Reset mid-operation: Rst_n low at E2 -> Out=0, Ry=0, Busy=0 immediately; a fresh En after release gives the correct 5-cycle result.
- Single-column check: In=db135345 repeated in all columns, Last=0 -> every column of Out=8e4da1bc (a uniform state is invariant under ShiftRows).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath definitions for the ShiftRows/MixColumns round stage.
// Contents:
//   - state_t / column_t    128-bit state and 32-bit column types
//   - StIdle/StCol/StDone   FSM state encoding (2 bits)
//   - MixCoef / InvMixCoef  first row of the (Inv)MixColumns circulant matrix
//   - byte_lsb()            LSB bit position of state byte (row, col)
//   - xtime() / gf_mul()    GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  column_t;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCol  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Coefficient for a_j in output row i is byte ((j - i) mod 4), MSB byte first.
  localparam logic [31:0] MixCoef    = 32'h0203_0101;
  localparam logic [31:0] InvMixCoef = 32'h0e0b_0d09;

  // Byte k = 4*col + row lives at state[127-8k -: 8], i.e. LSB at 120-8k.
  function automatic int unsigned byte_lsb(input int unsigned row, input int unsigned col);
    return 120 - 8 * (4 * col + row);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; folds to a few XORs when b is a constant.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns of one 32-bit column (byte 0 in bits 31:24).
// Optional macro SMC_INVERSE_EN adds the inv_i select for InvMixColumns.
// Ports:
//   col_i  in  32  column a0..a3
//   inv_i  in  1   select InvMixColumns (only with SMC_INVERSE_EN)
//   col_o  out 32  column b0..b3
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
`ifdef SMC_INVERSE_EN
  input  logic        inv_i,
`endif
  output logic [31:0] col_o
);

  logic [31:0] coef;
  logic [7:0]  acc;

  always_comb begin
`ifdef SMC_INVERSE_EN
    coef = inv_i ? InvMixCoef : MixCoef;
`else
    coef = MixCoef;
`endif
    col_o = '0;
    acc   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      acc = '0;
      for (int unsigned j = 0; j < 4; j++) begin
        acc ^= gf_mul(col_i[31 - 8 * j -: 8], coef[31 - 8 * ((j + 4 - i) % 4) -: 8]);
      end
      col_o[31 - 8 * i -: 8] = acc;
    end
  end

endmodule

// File: rtl/shift_mix_columns.sv
// AES round stage after SubBytes: ShiftRows then MixColumns, one column per
// clock, with a one-cycle Ry_SMC pulse when Out_SMC is updated.
// Optional macro SMC_INVERSE_EN adds Inv_SMC and the inverse datapath
// (InvMixColumns per column, then InvShiftRows on completion).
// Ports:
//   Clk       in  1    rising-edge clock
//   Rst_n     in  1    asynchronous active-low reset
//   En_SMC    in  1    start request, sampled only when idle
//   Last_SMC  in  1    final round: skip MixColumns
//   Inv_SMC   in  1    inverse mode (only with SMC_INVERSE_EN)
//   In_SMC    in  128  input state
//   Out_SMC   out 128  result, held until the next completion
//   Ry_SMC    out 1    one-cycle pulse: Out_SMC valid
//   Busy_SMC  out 1    high whenever not idle
module shift_mix_columns
  import aes_pkg::*;
(
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         En_SMC,
  input  logic         Last_SMC,
`ifdef SMC_INVERSE_EN
  input  logic         Inv_SMC,
`endif
  input  logic [127:0] In_SMC,
  output logic [127:0] Out_SMC,
  output logic         Ry_SMC,
  output logic         Busy_SMC
);

  logic [1:0] fsm_q, fsm_d;
  logic [1:0] col_q, col_d;
  state_t     state_q, state_d;
  state_t     out_q, out_d;
  logic       ry_q, ry_d;
  column_t    col_sel, col_mixed;

  function automatic state_t shift_rows(input state_t s);
    state_t r;
    r = '0;
    for (int unsigned row = 0; row < 4; row++) begin
      for (int unsigned col = 0; col < 4; col++) begin
        r[byte_lsb(row, col) +: 8] = s[byte_lsb(row, (col + row) % 4) +: 8];
      end
    end
    return r;
  endfunction

`ifdef SMC_INVERSE_EN
  logic inv_q, inv_d;

  function automatic state_t inv_shift_rows(input state_t s);
    state_t r;
    r = '0;
    for (int unsigned row = 0; row < 4; row++) begin
      for (int unsigned col = 0; col < 4; col++) begin
        r[byte_lsb(row, col) +: 8] = s[byte_lsb(row, (col + 4 - row) % 4) +: 8];
      end
    end
    return r;
  endfunction
`endif

  always_comb begin
    col_sel = '0;
    unique case (col_q)
      2'd0: col_sel = state_q[127:96];
      2'd1: col_sel = state_q[95:64];
      2'd2: col_sel = state_q[63:32];
      2'd3: col_sel = state_q[31:0];
    endcase
  end

  mix_column_unit u_mix (
    .col_i (col_sel),
`ifdef SMC_INVERSE_EN
    .inv_i (inv_q),
`endif
    .col_o (col_mixed)
  );

  always_comb begin
    fsm_d   = fsm_q;
    col_d   = col_q;
    state_d = state_q;
    out_d   = out_q;
    ry_d    = 1'b0;
`ifdef SMC_INVERSE_EN
    inv_d   = inv_q;
`endif
    unique case (fsm_q)
      StIdle: begin
        if (En_SMC) begin
`ifdef SMC_INVERSE_EN
          inv_d   = Inv_SMC;
          // Inverse mode unshifts at the end, after InvMixColumns.
          state_d = Inv_SMC ? In_SMC : shift_rows(In_SMC);
`else
          state_d = shift_rows(In_SMC);
`endif
          if (Last_SMC) begin
            fsm_d = StDone;
          end else begin
            col_d = 2'd0;
            fsm_d = StCol;
          end
        end
      end
      StCol: begin
        unique case (col_q)
          2'd0: state_d[127:96] = col_mixed;
          2'd1: state_d[95:64]  = col_mixed;
          2'd2: state_d[63:32]  = col_mixed;
          2'd3: state_d[31:0]   = col_mixed;
        endcase
        // Wraps 3 -> 0 as the FSM leaves for DONE.
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) fsm_d = StDone;
      end
      StDone: begin
`ifdef SMC_INVERSE_EN
        out_d = inv_q ? inv_shift_rows(state_q) : state_q;
`else
        out_d = state_q;
`endif
        ry_d  = 1'b1;
        fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fsm_q   <= StIdle;
      col_q   <= 2'd0;
      state_q <= '0;
      out_q   <= '0;
      ry_q    <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      col_q   <= col_d;
      state_q <= state_d;
      out_q   <= out_d;
      ry_q    <= ry_d;
    end
  end

`ifdef SMC_INVERSE_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
`endif

  assign Out_SMC  = out_q;
  assign Ry_SMC   = ry_q;
  assign Busy_SMC = (fsm_q != StIdle);

endmodule
